// File: rtl/conv3x3_stream_if.sv
// Handshake bundle for conv3x3_stream: pixel stream in, convolution results out,
// plus the per-frame completion pulse and threshold decision.
interface conv3x3_stream_if #(
    parameter int PIX_W = 5,
    parameter int OUT_W = 9
);
    logic [1:0]       m;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pix;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_pix;
    logic             out_last;
    logic             frame_done;
    logic             ans;

    modport master (
        output m, in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_pix, out_last, frame_done, ans
    );

    modport slave (
        input  m, in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_pix, out_last, frame_done, ans
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 binary-mask convolution over a raster frame, using two line buffers,
// a backpressured result register and a saturating per-frame total for the threshold decision.
module conv3x3_stream #(
    parameter int          IMG_W  = 4,
    parameter int          IMG_H  = 4,
    parameter int          PIX_W  = 5,
    parameter int          OUT_W  = 9,
    parameter int unsigned THRESH = 40,
    parameter logic [8:0]  K0     = 9'b100110000,
    parameter logic [8:0]  K1     = 9'b000010111,
    parameter logic [8:0]  K2     = 9'b111000111,
    parameter logic [8:0]  K3     = 9'b111111111
) (
    input logic              clk,
    input logic              rst,
    conv3x3_stream_if.slave  bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int SUM_W = PIX_W + 4;
    localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [1:0]       r_modeQ;
    logic [31:0]      r_acc;
    logic [PIX_W-1:0] r_line0 [IMG_W];
    logic [PIX_W-1:0] r_line1 [IMG_W];
    logic [PIX_W-1:0] r_win   [3][2];

    logic             w_inReady;
    logic             w_accept;
    logic             w_lastPix;
    logic             w_winDone;
    logic             w_outFire;
    logic [8:0]       w_mask;
    logic [PIX_W-1:0] w_win [3][3];
    logic [SUM_W-1:0] w_sum;
    logic [CMP_W-1:0] w_sumExt;
    logic [OUT_W-1:0] w_sat;
    logic [32:0]      w_accSum;
    logic [31:0]      w_accNext;

    always_comb begin
        w_inReady = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE:    w_inReady = 1'b1;
                RUN:     w_inReady = !bus.out_valid || bus.out_ready;
                default: w_inReady = 1'b0;
            endcase
        end
    end

    assign bus.in_ready = w_inReady;
    assign w_accept     = bus.in_valid && w_inReady;
    assign w_lastPix    = (r_row == ROW_W'(IMG_H - 1)) && (r_col == COL_W'(IMG_W - 1));
    assign w_winDone    = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_outFire    = bus.out_valid && bus.out_ready;

    always_comb begin
        case (r_modeQ)
            2'd0:    w_mask = K0;
            2'd1:    w_mask = K1;
            2'd2:    w_mask = K2;
            default: w_mask = K3;
        endcase
    end

    // The right-hand window column is the incoming pixel plus the two buffered pixels above it.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                w_win[r][c] = r_win[r][c];
            end
        end
        w_win[0][2] = r_line1[r_col];
        w_win[1][2] = r_line0[r_col];
        w_win[2][2] = bus.in_pix;
        w_sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (w_mask[8 - (r * 3 + c)]) begin
                    w_sum = w_sum + SUM_W'(w_win[r][c]);
                end
            end
        end
    end

    assign w_sumExt  = CMP_W'(w_sum);
    assign w_sat     = (w_sumExt > CMP_W'({OUT_W{1'b1}})) ? '1 : w_sumExt[OUT_W-1:0];
    assign w_accSum  = {1'b0, r_acc} + 33'(bus.out_pix);
    assign w_accNext = w_accSum[32] ? '1 : w_accSum[31:0];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line1[r_col] <= r_line0[r_col];
            r_line0[r_col] <= bus.in_pix;
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= w_win[r][2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_modeQ        <= '0;
            r_acc          <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_pix    <= '0;
            bus.out_last   <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.ans        <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            if (w_accept) begin
                if (r_col == COL_W'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_W'(IMG_H - 1)) ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
            // A new window reloads the register even while the old result is leaving.
            if (w_winDone) begin
                bus.out_valid <= 1'b1;
                bus.out_pix   <= w_sat;
                bus.out_last  <= w_lastPix;
            end else if (w_outFire) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
            if (w_outFire) begin
                r_acc <= w_accNext;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_modeQ <= bus.m;
                    end
                end
                RUN: begin
                    if (w_accept && w_lastPix) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_outFire && bus.out_last) begin
                        r_state        <= DONE;
                        bus.frame_done <= 1'b1;
                        bus.ans        <= (w_accNext > THRESH);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_acc   <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3x3 binary-mask convolution engine. It accepts an IMG_W x IMG_H frame of unsigned pixels in raster order over a valid/ready handshake and buffers two lines internally. It emits one result per valid (non-padded) window position, (IMG_W-2)*(IMG_H-2) per frame, under output backpressure. At end of frame it raises a one-cycle frame_done with a threshold decision `ans` on the frame's total. It generalises the fixed 4x4 combinational convolver to arbitrary frame size, a streaming interface, and selectable kernel masks.

## Interface
- IMG_W, 4, pixels per line (>=3)
- IMG_H, 4, lines per frame (>=3)
- PIX_W, 5, input pixel width, unsigned
- OUT_W, 9, result width; results saturate to 2^OUT_W-1
- THRESH, 40, ans=1 when frame total > THRESH
- K0..K3, 9'b100110000 / 9'b000010111 / 9'b111000111 / 9'b111111111, masks; MSB = window top-left, row-major, LSB = bottom-right
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m  in  2  kernel select (K0..K3), sampled on first pixel of frame
- in_valid  in  1  pixel valid
- in_ready  out  1  engine accepts pixel
- in_pix  in  PIX_W  pixel value
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_pix  out  OUT_W  convolution result
- out_last  out  1  marks final result of frame
- frame_done  out  1  one-cycle pulse, frame complete
- ans  out  1  threshold decision for last completed frame

## Operation
- Pixel accepted when in_valid && in_ready; col counter 0..IMG_W-1, row counter 0..IMG_H-1, raster order.
- Two line buffers (IMG_W x PIX_W each) plus a 3x3 window register; window shifts on each accepted pixel.
- Window complete when accepted pixel has row>=2 && col>=2. Result = sum of window pixels where mask bit = 1, saturated to OUT_W bits, then loaded into the output register.
- Windows never straddle a line: col<2 positions produce no output.
- Mode: m latched into mode_q on acceptance of pixel (0,0); later changes to m within the frame are ignored.
- Frame accumulator (32 bits, saturating) adds each saturated out_pix at its output handshake and clears at frame_done.
- FSM:
  - IDLE: in_ready=1. Transition to RUN on acceptance of (0,0).
  - RUN: in_ready = !out_valid || out_ready. Acceptance of (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: in_ready=0. Handshake of the out_last result -> DONE.
  - DONE: one cycle. frame_done=1, ans <= (acc > THRESH), acc cleared, counters at 0. Transition to IDLE.
- out_last=1 on the result from window (IMG_H-1, IMG_W-1).
- Output register holds out_pix/out_last stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0 during rst, 1 in the cycle after rst deasserts (IDLE). out_valid=0, out_pix=0, out_last=0, frame_done=0, ans=0. FSM=IDLE, counters=0, acc=0, mode_q=0.
- Latency: pixel completing a window accepted at edge N gives out_valid=1 after edge N (visible cycle N+1).
- Back-to-back: with out_ready held at 1, one pixel per cycle and one result per cycle with no bubbles.
- Stall: out_valid && !out_ready forces in_ready=0 in RUN, so no result is ever overwritten or dropped.
- Simultaneous out handshake and new window pixel accept: the output register reloads in the same edge, so out_valid stays 1.
- frame_done is asserted the cycle after the out_last handshake. ans changes only on that edge and holds until the next frame_done or rst.
- The next frame's (0,0) is accepted no earlier than the cycle after frame_done.
- rst mid-frame: all state returns to reset values on that edge. Partial frame is discarded, no frame_done is issued, and ans is cleared to 0.

## Test plan
- 4x4 frame with pixels 1..16, m=3, out_ready=1 -> out_pix 54, 63, 90, 99; out_last on 99; frame_done 1 cycle later; ans=1.
- Same frame, m=0 -> 12, 15, 24, 27 and ans=1. m=1 -> 36, 40, 52, 56. m=2 -> 36, 42, 60, 66.
- 4x4 all-ones frame, m=0 -> four results of 3, total 12, ans=0. m toggled mid-frame -> results unchanged.
- Random out_ready (50%) on the 1..16, m=3 frame -> same four values in order. out_pix is stable during stalls, and in_ready=0 whenever out_valid && !out_ready.
- OUT_W=8, all pixels 31, m=3 -> each result saturates to 255. IMG_W=6, IMG_H=5 -> exactly 12 results, out_last only on the 12th.
- rst asserted after the 10th pixel of a frame -> outputs return to reset values next cycle and no frame_done is issued. A following full 1..16, m=3 frame gives the correct 54, 63, 90, 99.
